load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters: none; all widths fixed at 32-bit data and 30-bit word address.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  1  request present; req_ready  out  1  unit idle.
REQ-005 req_store  in  1  1=store, 0=load; req_funct3  in  3  RV32I funct3 of LB/LH/LW/LBU/LHU/SB/SH/SW.
REQ-006 req_addr  in  32  byte address (ALU result); req_wdata  in  32  store data, low-aligned.
REQ-007 rsp_valid  out  1  one-cycle completion pulse; rsp_rdata  out  32  extended load data, 0 for stores; rsp_err  out  1  request rejected.
REQ-008 mem_en, mem_we  out  1 each; mem_addr  out  30  word address; mem_be  out  4  byte lanes; mem_wdata  out  32.
REQ-009 mem_rdata  in  32  read data, valid exactly one cycle after mem_en=1, mem_we=0.

Function
REQ-010 FSM states IDLE, ACC0, ACC1, RESP; req_ready=1 only in IDLE.
REQ-011 Handshake on req_valid&req_ready; all req_* fields latched then; req_* ignored in other cycles.
REQ-012 Size: funct3[1:0] 00=1, 01=2, 10=4 bytes; loads with funct3[2]=1 zero-extend, otherwise sign-extend.
REQ-013 Illegal: funct3 011/110/111, or store with funct3[2]=1 -> IDLE->RESP, rsp_err=1, no mem_en.
REQ-014 Offset o=addr[1:0]; access spans when o+size>4 (LH@o=3, LW@o!=0); other unaligned accesses are single-beat.
REQ-015 IDLE->ACC0 on legal handshake; ACC0 issues beat 0: mem_addr=addr[31:2], mem_be=(size mask<<o)[3:0].
REQ-016 ACC0->ACC1 if spanning, else ->RESP; ACC1 issues beat 1: mem_addr=addr[31:2]+1 mod 2^30, mem_be=(size mask<<o)[7:4].
REQ-017 Store lanes: 64-bit value {32'b0,wdata}<<8*o; low half -> beat 0 mem_wdata, high half -> beat 1.
REQ-018 In ACC1 the beat-0 mem_rdata is captured in a hold register.
REQ-019 RESP: rsp_valid=1 for exactly one cycle, then ->IDLE; load result = ({beat1 rdata or 0, beat0 rdata}>>8*o) truncated to size, extended per REQ-012.
REQ-020 Latency from handshake edge to rsp_valid: 2 cycles single-beat, 3 cycles split, 1 cycle error.
REQ-021 mem_en=1 only in ACC0/ACC1; mem_we=req_store; mem_be/mem_wdata=0 when mem_en=0.
REQ-022 Lanes outside mem_be are never modified by this unit; mem_be=0000 never issued with mem_en=1.

Reset
REQ-023 Reset has priority over all transitions: state=IDLE, hold register=0.
REQ-024 Output reset values: req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_en=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
REQ-025 Reset mid-operation aborts: no further beat, no rsp_valid; a completed beat-0 store stays written.

Configuration
REQ-026 Macro LSU_MISALIGNED_EN defined: spanning accesses split per REQ-016.
REQ-027 Macro undefined: spanning access handled as REQ-013 (rsp_err=1, 1-cycle latency, no mem_en); ACC1 removed.

Structure
REQ-028 Package lsu_pkg holds funct3 constants, size encodings and the FSM state typedef.
REQ-029 Sub-module lsu_align: combinational byte-lane shift, mask generation and load extension; FSM and registers stay in load_store_unit.

Verification
REQ-030 SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> mem_addr 0x4, be 1111; rsp_rdata 0xDEADBEEF 2 cycles after handshake.
REQ-031 Word@0x10=0x80FF0000: LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LHU 0x11 -> 0x0000FF00.
REQ-032 Word@0x8=0xAB000000, @0xC=0x000000CD: LH 0x0B -> beats (0x2,1000),(0x3,0001), rsp_rdata 0xFFFFCDAB at +3; macro off -> rsp_err=1, mem_en never 1.
REQ-033 SW 0x11223344 at 0x7D -> beat0 addr 0x1F be 1110 wdata 0x22334400; beat1 addr 0x20 be 0001 wdata 0x00000011.
REQ-034 Load funct3=011 -> rsp_valid, rsp_err=1 one cycle after handshake, mem_en stays 0.
REQ-035 Reset asserted during ACC1 of split store -> no beat-1 write, no rsp_valid, req_ready=1 first cycle after reset release.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_pkg
//  Brief    : Shared funct3 constants, access-size encodings, FSM state type
//             and request-classification helpers for the load/store unit.
//  Revision : 1.0  initial release
// ============================================================================
package lsu_pkg;

    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    localparam logic [1:0] c_SIZE_B = 2'b00;
    localparam logic [1:0] c_SIZE_H = 2'b01;
    localparam logic [1:0] c_SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC0 = 2'd1,
        ST_ACC1 = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_t;

    function automatic logic f_illegal(input logic store, input logic [2:0] funct3);
        logic legal;
        legal = (funct3 inside {c_F3_B, c_F3_H, c_F3_W}) ||
                (!store && (funct3 inside {c_F3_BU, c_F3_HU}));
        return !legal;
    endfunction

    // True when the access crosses into the next word (offset + size > 4).
    function automatic logic f_spans(input logic [1:0] size, input logic [1:0] offset);
        logic result;
        case (size)
            c_SIZE_H: result = (offset == 2'd3);
            c_SIZE_W: result = (offset != 2'd0);
            default:  result = 1'b0;
        endcase
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_align
//  Brief    : Combinational byte-lane steering: byte-enable masks, store data
//             shift into lanes, and load data realignment with extension.
//  Revision : 1.0  initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        zero_ext,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata_lo,
    input  logic [31:0] rdata_hi,
    output logic [3:0]  be_lo,
    output logic [3:0]  be_hi,
    output logic [31:0] wdata_lo,
    output logic [31:0] wdata_hi,
    output logic [31:0] load_data
);

    logic [3:0]  w_mask;
    logic [7:0]  w_be_all;
    logic [63:0] w_wide_wdata;
    logic [63:0] w_wide_rdata;
    logic [31:0] w_shifted;

    always_comb begin
        w_mask = 4'b0000;
        case (size)
            c_SIZE_B: w_mask = 4'b0001;
            c_SIZE_H: w_mask = 4'b0011;
            c_SIZE_W: w_mask = 4'b1111;
            default:  w_mask = 4'b0000;
        endcase
    end

    assign w_be_all     = {4'b0000, w_mask} << offset;
    assign be_lo        = w_be_all[3:0];
    assign be_hi        = w_be_all[7:4];

    assign w_wide_wdata = {32'h0, store_data} << {offset, 3'b000};
    assign wdata_lo     = w_wide_wdata[31:0];
    assign wdata_hi     = w_wide_wdata[63:32];

    // Two-beat window shifted down so the addressed byte lands in lane 0.
    assign w_wide_rdata = {rdata_hi, rdata_lo};
    assign w_shifted    = w_wide_rdata[{offset, 3'b000} +: 32];

    always_comb begin
        load_data = w_shifted;
        case (size)
            c_SIZE_B: load_data = zero_ext ? {24'h0, w_shifted[7:0]}
                                           : {{24{w_shifted[7]}}, w_shifted[7:0]};
            c_SIZE_H: load_data = zero_ext ? {16'h0, w_shifted[15:0]}
                                           : {{16{w_shifted[15]}}, w_shifted[15:0]};
            default:  load_data = w_shifted;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Brief    : RV32I load/store unit with single-request FSM driving a
//             word-addressed memory port. Define LSU_MISALIGNED_EN to split
//             word-crossing accesses into two beats; otherwise they error.
//  Revision : 1.0  initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    lsu_state_t  r_state;
    lsu_state_t  w_next;
    logic        r_store;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_err;

    logic        w_handshake;
    logic        w_req_err;
    logic [31:0] w_rdata_lo;
    logic [31:0] w_rdata_hi;
    logic [3:0]  w_be_lo;
    logic [3:0]  w_be_hi;
    logic [31:0] w_wdata_lo;
    logic [31:0] w_wdata_hi;
    logic [31:0] w_load_data;

    assign w_handshake = req_valid && (r_state == ST_IDLE);

`ifdef LSU_MISALIGNED_EN
    logic        r_hold;
    logic [31:0] r_hold_data;
    logic        w_spans;

    assign w_spans    = f_spans(r_funct3[1:0], r_addr[1:0]);
    assign w_req_err  = f_illegal(req_store, req_funct3);
    // Split loads see beat 0 in the hold register and beat 1 on the bus.
    assign w_rdata_lo = w_spans ? r_hold_data : mem_rdata;
    assign w_rdata_hi = w_spans ? mem_rdata   : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold      <= 1'b0;
            r_hold_data <= 32'h0;
        end else begin
            r_hold <= (r_state == ST_ACC1);
            if (r_state == ST_ACC1) begin
                r_hold_data <= mem_rdata;
            end
        end
    end
`else
    assign w_req_err  = f_illegal(req_store, req_funct3) ||
                        f_spans(req_funct3[1:0], req_addr[1:0]);
    assign w_rdata_lo = mem_rdata;
    assign w_rdata_hi = 32'h0;
`endif

    lsu_align u_align (
        .size       (r_funct3[1:0]),
        .offset     (r_addr[1:0]),
        .zero_ext   (r_funct3[2]),
        .store_data (r_wdata),
        .rdata_lo   (w_rdata_lo),
        .rdata_hi   (w_rdata_hi),
        .be_lo      (w_be_lo),
        .be_hi      (w_be_hi),
        .wdata_lo   (w_wdata_lo),
        .wdata_hi   (w_wdata_hi),
        .load_data  (w_load_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_store  <= 1'b0;
            r_funct3 <= 3'b000;
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_handshake) begin
                r_store  <= req_store;
                r_funct3 <= req_funct3;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_err    <= w_req_err;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_handshake) begin
                    w_next = w_req_err ? ST_RESP : ST_ACC0;
                end
            end
`ifdef LSU_MISALIGNED_EN
            ST_ACC0: w_next = w_spans ? ST_ACC1 : ST_RESP;
            ST_ACC1: w_next = ST_RESP;
`else
            ST_ACC0: w_next = ST_RESP;
`endif
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Outputs are forced to their reset values while reset is high so that an
    // aborted access never issues another beat in the reset cycle itself.
    always_comb begin
        req_ready = reset || (r_state == ST_IDLE);
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = 32'h0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 30'h0;
        mem_be    = 4'b0000;
        mem_wdata = 32'h0;
        if (!reset) begin
            case (r_state)
                ST_ACC0: begin
                    mem_en    = 1'b1;
                    mem_we    = r_store;
                    mem_addr  = r_addr[31:2];
                    mem_be    = w_be_lo;
                    mem_wdata = w_wdata_lo;
                end
`ifdef LSU_MISALIGNED_EN
                ST_ACC1: begin
                    mem_en    = 1'b1;
                    mem_we    = r_store;
                    mem_addr  = r_addr[31:2] + 30'd1;
                    mem_be    = w_be_hi;
                    mem_wdata = w_wdata_hi;
                end
`endif
                ST_RESP: begin
                    rsp_valid = 1'b1;
                    rsp_err   = r_err;
                    rsp_rdata = (r_store || r_err) ? 32'h0 : w_load_data;
                end
                default: ;
            endcase
        end
    end

`ifndef LSU_MISALIGNED_EN
    logic w_unused;
    assign w_unused = ^{w_be_hi, w_wdata_hi};
`endif

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_load_store_unit
//  Brief    : Directed self-checking bench for load_store_unit with a small
//             word memory model; expectations follow LSU_MISALIGNED_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_en;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:63];
    int          n_checks;
    int          n_errors;

    load_store_unit dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-lane memory with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[b]) mem[mem_addr[5:0]][8*b +: 8] = mem_wdata[8*b +: 8];
                end
            end else begin
                mem_rdata <= mem[mem_addr[5:0]];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for one cycle; returns just after the handshake edge.
    task automatic issue(input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        req_store  = st;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        req_valid  = 1'b1;
        tick();
        req_valid  = 1'b0;
        req_addr   = 32'hFFFF_FFFF;
        req_wdata  = 32'h0BAD_0BAD;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem_rdata  = 32'h0;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        tick();
        tick();

        // Reset values
        check("rst_req_ready", {31'h0, req_ready}, 32'h1);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_rsp_err",   {31'h0, rsp_err},   32'h0);
        check("rst_rsp_rdata", rsp_rdata,          32'h0);
        check("rst_mem_en",    {31'h0, mem_en},    32'h0);
        check("rst_mem_we",    {31'h0, mem_we},    32'h0);
        check("rst_mem_be",    {28'h0, mem_be},    32'h0);
        check("rst_mem_addr",  {2'b00, mem_addr},  32'h0);
        check("rst_mem_wdata", mem_wdata,          32'h0);
        reset = 1'b0;
        tick();

        // SW 0x10 then LW 0x10
        issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        check("sw_mem_en",    {31'h0, mem_en},   32'h1);
        check("sw_mem_we",    {31'h0, mem_we},   32'h1);
        check("sw_mem_addr",  {2'b00, mem_addr}, 32'h4);
        check("sw_mem_be",    {28'h0, mem_be},   32'hF);
        check("sw_mem_wdata", mem_wdata,         32'hDEADBEEF);
        check("sw_busy",      {31'h0, req_ready}, 32'h0);
        tick();
        check("sw_rsp_valid", {31'h0, rsp_valid}, 32'h1);
        check("sw_rsp_err",   {31'h0, rsp_err},   32'h0);
        check("sw_rsp_rdata", rsp_rdata,          32'h0);
        check("sw_rsp_mem_en", {31'h0, mem_en},   32'h0);
        tick();
        check("sw_pulse_end", {31'h0, rsp_valid}, 32'h0);
        check("sw_ready",     {31'h0, req_ready}, 32'h1);

        issue(1'b0, 3'b010, 32'h10, 32'h0);
        check("lw_mem_addr", {2'b00, mem_addr}, 32'h4);
        check("lw_mem_be",   {28'h0, mem_be},   32'hF);
        check("lw_mem_we",   {31'h0, mem_we},   32'h0);
        check("lw_mem_wdata", mem_wdata,        32'h0);
        tick();
        check("lw_rsp_valid", {31'h0, rsp_valid}, 32'h1);
        check("lw_rsp_rdata", rsp_rdata,          32'hDEADBEEF);
        tick();

        // Byte/half extension on word 0x80FF0000 at 0x10
        mem[4] = 32'h80FF0000;
        issue(1'b0, 3'b000, 32'h13, 32'h0);
        check("lb_mem_be", {28'h0, mem_be}, 32'h8);
        tick();
        check("lb_rdata", rsp_rdata, 32'hFFFFFF80);
        tick();
        issue(1'b0, 3'b100, 32'h13, 32'h0);
        tick();
        check("lbu_rdata", rsp_rdata, 32'h00000080);
        tick();
        issue(1'b0, 3'b101, 32'h11, 32'h0);
        check("lhu_mem_be", {28'h0, mem_be}, 32'h6);
        tick();
        check("lhu_rdata", rsp_rdata, 32'h0000FF00);
        tick();

        // Unaligned but non-spanning half, then spanning half
        mem[2] = 32'hAB000000;
        mem[3] = 32'h000000CD;
        issue(1'b0, 3'b001, 32'h0A, 32'h0);
        check("lh_o2_mem_be", {28'h0, mem_be}, 32'hC);
        tick();
        check("lh_o2_rdata", rsp_rdata, 32'hFFFFAB00);
        tick();

        issue(1'b0, 3'b001, 32'h0B, 32'h0);
`ifdef LSU_MISALIGNED_EN
        check("lh_split_b0_addr", {2'b00, mem_addr}, 32'h2);
        check("lh_split_b0_be",   {28'h0, mem_be},   32'h8);
        tick();
        check("lh_split_b1_en",   {31'h0, mem_en},   32'h1);
        check("lh_split_b1_addr", {2'b00, mem_addr}, 32'h3);
        check("lh_split_b1_be",   {28'h0, mem_be},   32'h1);
        tick();
        check("lh_split_valid", {31'h0, rsp_valid}, 32'h1);
        check("lh_split_err",   {31'h0, rsp_err},   32'h0);
        check("lh_split_rdata", rsp_rdata,          32'hFFFFCDAB);
`else
        check("lh_span_valid",  {31'h0, rsp_valid}, 32'h1);
        check("lh_span_err",    {31'h0, rsp_err},   32'h1);
        check("lh_span_mem_en", {31'h0, mem_en},    32'h0);
`endif
        tick();
        check("lh_span_idle", {31'h0, req_ready}, 32'h1);

        // Spanning word store at 0x7D
        issue(1'b1, 3'b010, 32'h7D, 32'h11223344);
`ifdef LSU_MISALIGNED_EN
        check("sw_split_b0_addr",  {2'b00, mem_addr}, 32'h1F);
        check("sw_split_b0_be",    {28'h0, mem_be},   32'hE);
        check("sw_split_b0_wdata", mem_wdata,         32'h22334400);
        tick();
        check("sw_split_b1_addr",  {2'b00, mem_addr}, 32'h20);
        check("sw_split_b1_be",    {28'h0, mem_be},   32'h1);
        check("sw_split_b1_wdata", mem_wdata,         32'h00000011);
        tick();
        check("sw_split_valid", {31'h0, rsp_valid}, 32'h1);
        check("sw_split_mem1F", mem[31], 32'h22334400);
        check("sw_split_mem20", mem[32], 32'h00000011);
`else
        check("sw_span_err",    {31'h0, rsp_err}, 32'h1);
        check("sw_span_mem_en", {31'h0, mem_en},  32'h0);
`endif
        tick();

        // Illegal funct3 load and illegal store encoding
        issue(1'b0, 3'b011, 32'h10, 32'h0);
        check("ill_ld_valid",  {31'h0, rsp_valid}, 32'h1);
        check("ill_ld_err",    {31'h0, rsp_err},   32'h1);
        check("ill_ld_mem_en", {31'h0, mem_en},    32'h0);
        check("ill_ld_rdata",  rsp_rdata,          32'h0);
        tick();
        check("ill_ld_clear",  {31'h0, rsp_err},   32'h0);
        issue(1'b1, 3'b100, 32'h10, 32'h12345678);
        check("ill_st_err",    {31'h0, rsp_err},   32'h1);
        check("ill_st_mem_en", {31'h0, mem_en},    32'h0);
        tick();
        check("ill_st_mem4",   mem[4],             32'h80FF0000);

        // Reset in the middle of a store
        mem[48] = 32'h0;
        mem[49] = 32'h0;
`ifdef LSU_MISALIGNED_EN
        issue(1'b1, 3'b010, 32'hC2, 32'hAABBCCDD);
        check("rst_split_b0_be",    {28'h0, mem_be}, 32'hC);
        check("rst_split_b0_wdata", mem_wdata,       32'hCCDD0000);
        tick();
        check("rst_split_b1_wdata", mem_wdata,       32'h0000AABB);
        reset = 1'b1;
        #1;
        check("rst_split_abort_en", {31'h0, mem_en}, 32'h0);
        tick();
        check("rst_split_no_rsp", {31'h0, rsp_valid}, 32'h0);
        reset = 1'b0;
        tick();
        check("rst_split_ready",  {31'h0, req_ready}, 32'h1);
        check("rst_split_no_rsp2", {31'h0, rsp_valid}, 32'h0);
        check("rst_split_mem30", mem[48], 32'hCCDD0000);
        check("rst_split_mem31", mem[49], 32'h0);
`else
        issue(1'b1, 3'b010, 32'hC0, 32'hAABBCCDD);
        check("rst_acc0_en", {31'h0, mem_en}, 32'h1);
        reset = 1'b1;
        #1;
        check("rst_acc0_abort_en", {31'h0, mem_en}, 32'h0);
        tick();
        check("rst_acc0_no_rsp", {31'h0, rsp_valid}, 32'h0);
        reset = 1'b0;
        tick();
        check("rst_acc0_ready",  {31'h0, req_ready}, 32'h1);
        check("rst_acc0_no_rsp2", {31'h0, rsp_valid}, 32'h0);
        check("rst_acc0_mem30",  mem[48], 32'h0);
`endif
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
